// File: rtl/dmem_ctrl.sv
// Data memory controller: single-outstanding word memory responder.
// Accepts one request at a time and answers after a fixed wait.
package dmem_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_type;
endpackage

module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] mem_base    = 32'h0,
  parameter int          mem_depth   = 10,
  parameter int          mem_latency = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out
);

  localparam logic [3:0] LAT = 4'(mem_latency);
  localparam int WORDS = 2 ** mem_depth;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic accept, commit, hit, wr_en;

  logic [31:0] q_addr, q_wdata;
  logic [3:0]  q_wstrb;
  logic        q_fence;

  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_wstrb;
  logic        c_fence;

  logic [32:0] diff;
  logic [31:0] off;
  logic [mem_depth-1:0] idx;
  logic [31:0] word, merged;

  logic        ready_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [WORDS] = '{default: '0};

  logic unused;
  assign unused = dmem_in.mem_instr;

  // next-state and counter control
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (dmem_in.mem_valid) begin
          accept = 1'b1;
          if (dmem_in.mem_fence || LAT == 4'd0) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = LAT;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // live request: straight from the port on the accept edge,
  // otherwise the latched copy
  always_comb begin
    c_addr  = q_addr;
    c_wdata = q_wdata;
    c_wstrb = q_wstrb;
    c_fence = q_fence;
    if (state == IDLE) begin
      c_addr  = dmem_in.mem_addr;
      c_wdata = dmem_in.mem_wdata;
      c_wstrb = dmem_in.mem_wstrb;
      c_fence = dmem_in.mem_fence;
    end
  end

  // address decode and byte-lane merge
  always_comb begin
    diff   = {1'b0, c_addr} - {1'b0, mem_base};
    off    = diff[31:0];
    idx    = off[mem_depth+1:2];
    hit    = !diff[32] && ((off >> (mem_depth + 2)) == 32'd0);
    word   = mem[idx];
    merged = word;
    for (int i = 0; i < 4; i++) begin
      if (c_wstrb[i]) begin
        merged[8*i +: 8] = c_wdata[8*i +: 8];
      end
    end
    commit = (state_nx == RESP);
    wr_en  = commit && hit && !c_fence && (c_wstrb != 4'd0);
  end

  // control state and registered response
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      ready_q <= commit;
      rdata_q <= (commit && hit && !c_fence) ? merged : 32'd0;
    end
  end

  // latch the request on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      q_addr  <= dmem_in.mem_addr;
      q_wdata <= dmem_in.mem_wdata;
      q_wstrb <= dmem_in.mem_wstrb;
      q_fence <= dmem_in.mem_fence;
    end
  end

  // array write on the edge entering RESP; reset never clears it
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem[idx] <= merged;
    end
  end

  assign dmem_out.mem_rdata = rdata_q;
  assign dmem_out.mem_ready = ready_q;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The parameter mem_base SHALL default to 32'h0 and give the byte address of word 0.
REQ-002 The parameter mem_depth SHALL default to 10 and give log2 of the number of 32-bit words.
REQ-003 The parameter mem_latency SHALL default to 2 and give the number of wait cycles per access (legal range 0..15).
REQ-004 The port list SHALL be as follows:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-low (rst==0 resets).
- dmem_in  in  mem_in_type  request: mem_valid, mem_fence, mem_instr, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0].
- dmem_out  out  mem_out_type  response: mem_rdata[31:0], mem_ready.

Function
REQ-005 The block SHALL be a single-outstanding responder with states IDLE, WAIT and RESP.
REQ-006 mem_valid SHALL be a level; a request is accepted only at a clk edge where the state is IDLE and mem_valid==1.
- Inputs in WAIT and RESP are ignored.
- A requester holding mem_valid high through RESP gets its next request accepted in the following IDLE cycle.
REQ-007 On acceptance the block SHALL register addr, wdata, wstrb and fence.
- mem_latency==0: next state RESP.
- Otherwise: next state WAIT, with the counter loaded to mem_latency.
REQ-008 In WAIT the counter SHALL decrement each cycle; on the edge where the counter equals 1, the next state is RESP.
REQ-009 mem_ready SHALL be registered and equal 1 only during RESP, for exactly one cycle. For a request accepted at edge k, ready is high in cycle k+1+mem_latency.
REQ-010 RESP SHALL always return to IDLE on the next edge; back-to-back accesses take mem_latency+2 cycles each.
REQ-011 The word index SHALL be (addr-mem_base)>>2. addr[1:0] is ignored, and the subtraction is 32-bit modulo.
REQ-012 An address is in range iff addr>=mem_base and the word index <2**mem_depth.
REQ-013 Write (wstrb!=0, fence==0, in range): on the edge entering RESP, only bytes i with wstrb[i]==1 SHALL take wdata[8i+7:8i]; mem_rdata in RESP shows the merged word.
REQ-014 Read (wstrb==0, fence==0, in range): mem_rdata in RESP SHALL be the array word sampled on the edge entering RESP, so a write accepted earlier is always visible.
REQ-015 Out-of-range access SHALL drop the write and return mem_rdata=0, with normal ready timing.
REQ-016 Fence (mem_fence==1) SHALL take precedence over wstrb, perform no array access, bypass WAIT (RESP on the next edge) and return mem_rdata=0.
REQ-017 mem_instr SHALL be ignored.
REQ-018 Outside RESP, mem_rdata SHALL be 0.
REQ-019 The array SHALL initialise to all zeros at time 0 and is never cleared by rst.

Reset
REQ-020 While rst==0 at an edge, the block SHALL go to state IDLE with counter=0, mem_ready=0 and mem_rdata=0.
REQ-021 Reset in WAIT SHALL discard the pending request; an uncommitted write never reaches the array.
REQ-022 The first request SHALL be acceptable in the first cycle with rst==1.

Verification
REQ-023 The bench SHALL cover these directed scenarios (mem_latency=2, mem_base=0):
- Write then read: write addr 0x10, data 0xDEADBEEF, wstrb 4'hF; then read 0x10. Each ready appears 3 cycles after acceptance; read mem_rdata=0xDEADBEEF.
- Partial write: word 0x10 =0xDEADBEEF; write 0x11223344 with wstrb 4'b0101; then read 0x10. Result 0xDE22BE44.
- Burst read: mem_valid held high for 8 words, address +4 in each ready cycle. Exactly 8 ready pulses, one every 4 cycles, data in order.
- Range and fence: read 0x1000 (depth 10) returns 0 and the array is unchanged. A fence returns ready 1 cycle after acceptance with rdata 0.
- Reset mid-write: rst=0 one cycle after acceptance of write 0x20=0x12345678. No ready; a later read of 0x20 returns 0.
- mem_latency=0: read accepted at edge k gives ready in cycle k+1; a second request in that RESP cycle is accepted at edge k+2.
